// File: rtl/cordic_multimode.sv
// Iterative CORDIC engine: rotation (sin/cos, vector rotate) and
// vectoring (magnitude/atan2), binary-turn angles, valid/ready on both sides.
// Ports:
//   clock, reset               rising-edge clock, async active-high reset
//   in_valid/in_ready          operand handshake
//   in_mode                    0 = rotation, 1 = vectoring
//   in_x, in_y                 signed operand (WIDTH)
//   in_z                       angle in turns (ANGLE_WIDTH), rotation only
//   in_tag                     sideband tag, returned with the result
//   out_valid/out_ready        result handshake
//   out_x, out_y, out_z        saturated x/y and final angle
//   out_mode, out_tag          mode and tag captured with the operand
//   out_sat                    out_x or out_y was clipped
module cordic_multimode #(
  parameter int WIDTH       = 16,
  parameter int ANGLE_WIDTH = 32,
  parameter int ITERATIONS  = 15,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic signed [WIDTH-1:0]       in_x,
  input  logic signed [WIDTH-1:0]       in_y,
  input  logic        [ANGLE_WIDTH-1:0] in_z,
  input  logic        [TAG_WIDTH-1:0]   in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WIDTH-1:0]       out_x,
  output logic signed [WIDTH-1:0]       out_y,
  output logic        [ANGLE_WIDTH-1:0] out_z,
  output logic                          out_mode,
  output logic        [TAG_WIDTH-1:0]   out_tag,
  output logic                          out_sat
);

  localparam int DW = WIDTH + 2;
  localparam int AW = ANGLE_WIDTH;
  localparam int CW = $clog2(ITERATIONS + 1);
  localparam int FB = 60;

  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef logic [ITERATIONS-1:0][AW-1:0] atan_tab_t;

  // atan(1/n) scaled by 2^FB, Taylor series.
  function automatic logic [63:0] atan_inv(input int n);
    logic [63:0] p;
    logic [63:0] acc;
    logic [63:0] term;
    logic [63:0] nn;
    acc = '0;
    nn  = 64'(n * n);
    p   = (64'd1 << FB) / 64'(n);
    for (int k = 0; k < 32; k++) begin
      term = p / 64'(2 * k + 1);
      if (k % 2 == 0) acc = acc + term;
      else acc = acc - term;
      p = p / nn;
    end
    return acc;
  endfunction

  // atan(2^-i) scaled by 2^FB, for i >= 1.
  function automatic logic [63:0] atan_pow2(input int i);
    logic [63:0] acc;
    logic [63:0] term;
    int          sh;
    acc = '0;
    for (int k = 0; k < 32; k++) begin
      sh = i * (2 * k + 1);
      if (sh <= FB) begin
        term = (64'd1 << (FB - sh)) / 64'(2 * k + 1);
        if (k % 2 == 0) acc = acc + term;
        else acc = acc - term;
      end
    end
    return acc;
  endfunction

  // round(atan(2^-i) / (2*pi) * 2^AW) using pi/4 from Machin's formula
  // and an exact shift-subtract division, so no real arithmetic is needed.
  function automatic atan_tab_t atan_table();
    atan_tab_t   tab;
    logic [63:0] q4;
    logic [63:0] t;
    logic [63:0] r;
    logic [63:0] q;
    q4 = (atan_inv(5) << 2) - atan_inv(239);
    for (int i = 0; i < ITERATIONS; i++) begin
      t = (i == 0) ? q4 : atan_pow2(i);
      r = t;
      q = '0;
      if (r >= q4) begin
        r = r - q4;
        q = 64'd1;
      end
      for (int b = 0; b < AW - 2; b++) begin
        r = r << 1;
        q = q << 1;
        if (r >= q4) begin
          r = r - q4;
          q = q | 64'd1;
        end
      end
      tab[i] = AW'((q + 64'd1) >> 1);
    end
    return tab;
  endfunction

  localparam atan_tab_t ATAN = atan_table();

  typedef enum logic [1:0] {
    IDLE,
    PREROT,
    ITER,
    DONE
  } state_e;

  state_e                 state_q;
  logic                   in_ready_q;
  logic                   mode_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [CW-1:0]          iter_q;
  logic signed [DW-1:0]   x_q, x_d;
  logic signed [DW-1:0]   y_q, y_d;
  logic [AW-1:0]          z_q, z_d;

  logic                   out_valid_q;
  logic [WIDTH-1:0]       out_x_q, out_y_q;
  logic [AW-1:0]          out_z_q;
  logic                   out_mode_q;
  logic [TAG_WIDTH-1:0]   out_tag_q;
  logic                   out_sat_q;

  logic signed [DW-1:0]   xs, ys;
  logic [AW-1:0]          atan_cur;
  logic                   d_pos;
  logic                   ovf_x, ovf_y;
  logic [WIDTH-1:0]       sat_x, sat_y;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    xs       = x_q >>> iter_q;
    ys       = y_q >>> iter_q;
    atan_cur = '0;
    for (int k = 0; k < ITERATIONS; k++) begin
      if (iter_q == CW'(k)) atan_cur = ATAN[k];
    end
    d_pos = mode_q ? y_q[DW-1] : ~z_q[AW-1];
    unique case (state_q)
      PREROT: begin
        if (!mode_q) begin
          // |z| > pi/2: rotate by pi so the iterations can converge
          if (z_q[AW-1] ^ z_q[AW-2]) begin
            x_d = -x_q;
            y_d = -y_q;
            z_d = {~z_q[AW-1], z_q[AW-2:0]};
          end
        end else begin
          z_d = '0;
          if (x_q[DW-1]) begin
            x_d = -x_q;
            y_d = -y_q;
            z_d = {1'b1, {(AW-1){1'b0}}};
          end
        end
      end
      ITER: begin
        if (iter_q != CW'(ITERATIONS)) begin
          if (d_pos) begin
            x_d = x_q - ys;
            y_d = y_q + xs;
            z_d = z_q - atan_cur;
          end else begin
            x_d = x_q + ys;
            y_d = y_q - xs;
            z_d = z_q + atan_cur;
          end
        end
      end
      default: ;
    endcase
  end

  // Overflow when the guard bits differ from the WIDTH sign bit.
  always_comb begin
    ovf_x = ~((&x_q[DW-1:WIDTH-1]) | ~(|x_q[DW-1:WIDTH-1]));
    ovf_y = ~((&y_q[DW-1:WIDTH-1]) | ~(|y_q[DW-1:WIDTH-1]));
    sat_x = ovf_x ? (x_q[DW-1] ? MINV : MAXV) : x_q[WIDTH-1:0];
    sat_y = ovf_y ? (y_q[DW-1] ? MINV : MAXV) : y_q[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      mode_q      <= 1'b0;
      tag_q       <= '0;
      iter_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      out_mode_q  <= 1'b0;
      out_tag_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= {{2{in_x[WIDTH-1]}}, in_x};
            y_q        <= {{2{in_y[WIDTH-1]}}, in_y};
            z_q        <= in_z;
            mode_q     <= in_mode;
            tag_q      <= in_tag;
            in_ready_q <= 1'b0;
            state_q    <= PREROT;
          end
        end
        PREROT: begin
          x_q     <= x_d;
          y_q     <= y_d;
          z_q     <= z_d;
          iter_q  <= '0;
          state_q <= ITER;
        end
        ITER: begin
          // The extra count after the last micro-rotation loads the
          // saturated result registers.
          if (iter_q == CW'(ITERATIONS)) begin
            out_x_q     <= sat_x;
            out_y_q     <= sat_y;
            out_z_q     <= z_q;
            out_mode_q  <= mode_q;
            out_tag_q   <= tag_q;
            out_sat_q   <= ovf_x | ovf_y;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            iter_q <= iter_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;
  assign out_mode  = out_mode_q;
  assign out_tag   = out_tag_q;
  assign out_sat   = out_sat_q;

endmodule
